// File: rtl/dmem_pkg.sv
// Shared types and helpers for the load/store data memory.
// Build option: DMEM_CLEAR_EN enables the post-reset zero-fill sweep in dmem_lsu.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RESP  = 2'b01,
    ST_CLEAR = 2'b10
  } state_e;

  // byte_bits is log2 of the memory size in bytes; any higher address bit is out of range.
  function automatic logic access_fault(input logic [1:0] size, input logic [31:0] addr,
                                        input int unsigned byte_bits);
    logic bad_align;
    logic bad_range;
    case (size)
      SZ_B:    bad_align = 1'b0;
      SZ_H:    bad_align = addr[0];
      SZ_W:    bad_align = (addr[1:0] != 2'b00);
      default: bad_align = 1'b1;
    endcase
    bad_range = ((addr >> byte_bits) != 32'd0);
    return bad_align | bad_range;
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_B:    return 4'b0001 << lane;
      SZ_H:    return lane[1] ? 4'b1100 : 4'b0011;
      SZ_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic uns);
    logic [31:0] shifted;
    shifted = word >> {lane, 3'b000};
    case (size)
      SZ_B:    return uns ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H:    return uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port synchronous RAM with byte-lane write enables and a registered read port.
// The read register only updates when en is high, so it holds the last word read.
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 2048,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Read-first port: byte-lane writes and word read on the same enabled edge.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of a byte-lane RAM: alignment/range faults, lane steering, extension.
// Build option: DMEM_CLEAR_EN adds a zero-fill sweep of the whole RAM after every reset.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 2048
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_RESP = ST_RESP;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic          accept;
  logic          fault;
  logic          clearing;
  logic [AW-1:0] clr_cnt;
  logic          bank_en;
  logic [3:0]    bank_we;
  logic [AW-1:0] bank_addr;
  logic [31:0]   bank_wdata;
  logic [31:0]   bank_rdata;
  logic [1:0]    rsp_lane;
  logic [1:0]    rsp_size;
  logic          rsp_uns;
  logic          rsp_load;

`ifdef DMEM_CLEAR_EN
  localparam logic [1:0]    S_CLEAR   = ST_CLEAR;
  localparam logic [1:0]    S_RESET   = S_CLEAR;
  localparam logic [AW-1:0] LAST_WORD = {AW{1'b1}};

  assign clearing = (state == S_CLEAR) && !reset;

  // Sweep pointer: word k is zeroed on the k-th edge after reset is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt <= {AW{1'b0}};
    end else if (clearing) begin
      clr_cnt <= clr_cnt + {{(AW-1){1'b0}}, 1'b1};
    end
  end
`else
  localparam logic [1:0] S_RESET = S_IDLE;

  assign clearing = 1'b0;
  assign clr_cnt  = {AW{1'b0}};
`endif

  assign req_ready = !reset && ((state == S_IDLE) || ((state == S_RESP) && rsp_ready));
  assign accept    = req_valid && req_ready;
  assign fault     = access_fault(req_size, req_addr, AW + 2);

  // RAM port steering: sweep has priority; stores replicate data across lanes and mask.
  always_comb begin
    bank_en    = accept || clearing;
    bank_we    = 4'h0;
    bank_addr  = req_addr[AW+1:2];
    bank_wdata = req_wdata;
    if (clearing) begin
      bank_we    = 4'hF;
      bank_addr  = clr_cnt;
      bank_wdata = 32'd0;
    end else begin
      case (req_size)
        SZ_B:    bank_wdata = {4{req_wdata[7:0]}};
        SZ_H:    bank_wdata = {2{req_wdata[15:0]}};
        default: bank_wdata = req_wdata;
      endcase
      if (accept && req_we && !fault) begin
        bank_we = lane_mask(req_size, req_addr[1:0]);
      end else begin
        bank_we = 4'h0;
      end
    end
  end

  // Next-state logic for the request/response handshake.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) state_next = S_RESP;
        else        state_next = S_IDLE;
      end
      S_RESP: begin
        if (!rsp_ready)     state_next = S_RESP;
        else if (req_valid) state_next = S_RESP;
        else                state_next = S_IDLE;
      end
`ifdef DMEM_CLEAR_EN
      S_CLEAR: begin
        if (clr_cnt == LAST_WORD) state_next = S_IDLE;
        else                      state_next = S_CLEAR;
      end
`endif
      default: state_next = S_RESET;
    endcase
  end

  // State and response context; the raw word itself stays in the RAM read register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_RESET;
      rsp_fault <= 1'b0;
      rsp_load  <= 1'b0;
      rsp_lane  <= 2'b00;
      rsp_size  <= 2'b00;
      rsp_uns   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        rsp_fault <= fault;
        rsp_load  <= !req_we && !fault;
        rsp_lane  <= req_addr[1:0];
        rsp_size  <= req_size;
        rsp_uns   <= req_unsigned;
      end
    end
  end

  assign rsp_valid = (state == S_RESP);
  assign rsp_rdata = rsp_load ? load_extend(bank_rdata, rsp_lane, rsp_size, rsp_uns) : 32'd0;

  dmem_bank #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_bank (
    .clk  (clk),
    .en   (bank_en),
    .we   (bank_we),
    .addr (bank_addr),
    .wdata(bank_wdata),
    .rdata(bank_rdata)
  );

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu (DEPTH_WORDS = 16): byte-array reference model plus literal checks.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  always #5 clk = ~clk;

  dmem_lsu #(.DEPTH_WORDS(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault)
  );

`ifdef DMEM_CLEAR_EN
  localparam int CLR = 16;
`else
  localparam int CLR = 0;
`endif

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
    logic        known;
  } rsp_t;

  int          checks = 0;
  int          errors = 0;
  rsp_t        q[$];
  logic [7:0]  mem_b [64];
  bit          known_b [64];
  bit          pending = 1'b0;
  bit          acc_now, popped;
  bit          after_reset = 1'b0;
  int          clear_left = 0;
  logic [31:0] last_rdata;
  logic        last_fault;
  logic [31:0] hold_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour of one accepted request, in terms of a little-endian byte array.
  task automatic model_access();
    bit          f;
    int          n;
    int          a;
    logic [31:0] v;
    logic [31:0] b;
    bit          kn;
    f = (req_size == 2'd3) || (req_size == 2'd1 && req_addr % 2 != 0) ||
        (req_size == 2'd2 && req_addr % 4 != 0) || (req_addr >= 32'd64);
    n = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : 4;
    if (f) begin
      q.push_back('{rdata: 32'd0, fault: 1'b1, known: 1'b1});
    end else begin
      a = int'(req_addr[5:0]);
      if (req_we) begin
        for (int i = 0; i < n; i++) begin
          b = req_wdata >> (8 * i);
          mem_b[a+i]   = b[7:0];
          known_b[a+i] = 1'b1;
        end
        q.push_back('{rdata: 32'd0, fault: 1'b0, known: 1'b1});
      end else begin
        v  = 32'd0;
        kn = 1'b1;
        for (int i = 0; i < n; i++) begin
          b  = {24'd0, mem_b[a+i]};
          v  = v + (b << (8 * i));
          kn = kn && known_b[a+i];
        end
        if (!req_unsigned && n == 1 && v >= 32'd128)   v = v + 32'hFFFFFF00;
        if (!req_unsigned && n == 2 && v >= 32'd32768) v = v + 32'hFFFF0000;
        q.push_back('{rdata: v, fault: 1'b0, known: kn});
      end
    end
  endtask

  // One clock: compare outputs against the model at the falling edge, then advance the model.
  task automatic step();
    bit   exp_ready;
    rsp_t h;
    @(negedge clk);
    exp_ready = !reset && (clear_left == 0) && (!pending || rsp_ready);
    chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, pending});
    if (pending) begin
      h = q[0];
      chk("rsp_fault", {31'd0, rsp_fault}, {31'd0, h.fault});
      if (h.known) chk("rsp_rdata", rsp_rdata, h.rdata);
    end
    if (after_reset) begin
      chk("reset_rdata", rsp_rdata, 32'd0);
      chk("reset_fault", {31'd0, rsp_fault}, 32'd0);
    end
    acc_now = 1'b0;
    popped  = 1'b0;
    if (reset) begin
      pending     = 1'b0;
      q.delete();
      after_reset = 1'b1;
      clear_left  = CLR;
    end else begin
      after_reset = 1'b0;
      if (clear_left > 0) begin
        clear_left--;
        if (clear_left == 0) begin
          for (int i = 0; i < 64; i++) begin
            mem_b[i]   = 8'h00;
            known_b[i] = 1'b1;
          end
        end
      end
      if (pending && rsp_ready) begin
        last_rdata = rsp_rdata;
        last_fault = rsp_fault;
        void'(q.pop_front());
        popped = 1'b1;
      end
      if (req_valid && exp_ready) begin
        model_access();
        acc_now = 1'b1;
      end
      pending = (q.size() != 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic we, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd);
    int n;
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    n = 0;
    do begin step(); n++; end while (!acc_now && n < 40);
    if (!acc_now) begin
      checks++; errors++;
      $display("FAIL accept_timeout: no accept within %0d cycles, addr %h", n, addr);
    end
    req_valid = 1'b0;
    n = 0;
    do begin step(); n++; end while (!popped && n < 40);
    if (!popped) begin
      checks++; errors++;
      $display("FAIL response_timeout: no response within %0d cycles, addr %h", n, addr);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    step();

    for (int w = 0; w < 16; w++) xfer(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom);

    // Sign/zero extension.
    xfer(1'b1, 2'd2, 1'b0, 32'h4, 32'h80FF7F01);
    xfer(1'b0, 2'd0, 1'b0, 32'h6, 32'd0); chk("lb_0x6", last_rdata, 32'hFFFFFFFF);
    xfer(1'b0, 2'd0, 1'b1, 32'h6, 32'd0); chk("lbu_0x6", last_rdata, 32'h000000FF);
    xfer(1'b0, 2'd1, 1'b0, 32'h6, 32'd0); chk("lh_0x6", last_rdata, 32'hFFFF80FF);
    xfer(1'b0, 2'd1, 1'b1, 32'h4, 32'd0); chk("lhu_0x4", last_rdata, 32'h00007F01);

    // Partial stores.
    xfer(1'b1, 2'd2, 1'b0, 32'h0, 32'h11223344);
    xfer(1'b1, 2'd1, 1'b0, 32'h2, 32'h0000BEEF);
    xfer(1'b1, 2'd0, 1'b0, 32'h0, 32'h000000AA);
    xfer(1'b0, 2'd2, 1'b0, 32'h0, 32'd0); chk("partial_lw", last_rdata, 32'hBEEF33AA);

    // Faults.
    xfer(1'b0, 2'd2, 1'b0, 32'h6, 32'd0);
    chk("lw_misalign_fault", {31'd0, last_fault}, 32'd1);
    chk("lw_misalign_rdata", last_rdata, 32'd0);
    xfer(1'b1, 2'd1, 1'b0, 32'h5, 32'h00001234);
    chk("sh_misalign_fault", {31'd0, last_fault}, 32'd1);
    xfer(1'b0, 2'd2, 1'b0, 32'h4, 32'd0); chk("sh_fault_unchanged", last_rdata, 32'h80FF7F01);
    xfer(1'b0, 2'd2, 1'b0, 32'h40, 32'd0);
    chk("lw_range_fault", {31'd0, last_fault}, 32'd1);
    xfer(1'b0, 2'd3, 1'b0, 32'h0, 32'd0);
    chk("size_rsv_fault", {31'd0, last_fault}, 32'd1);

    // Response held for three cycles.
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h4;
    req_valid = 1'b1; rsp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    hold_data = rsp_rdata;
    chk("hold_value", hold_data, 32'h80FF7F01);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_rdata", rsp_rdata, hold_data);
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    step();

    // Back-to-back store then load of the same word.
    req_we = 1'b1; req_size = 2'd2; req_addr = 32'h8; req_wdata = 32'h55; req_valid = 1'b1;
    step();
    req_we = 1'b0;
    step();
    chk("b2b_second_accept", {31'd0, acc_now}, 32'd1);
    req_valid = 1'b0;
    step();
    chk("b2b_load", last_rdata, 32'h00000055);

    // Reset with a pending response and a store on the reset edge.
    req_we = 1'b0; req_addr = 32'h8; req_valid = 1'b1; rsp_ready = 1'b0;
    step();
    reset = 1'b1; req_we = 1'b1; req_wdata = 32'hDEADBEEF;
    step();
    chk("reset_drops_rsp", {31'd0, rsp_valid}, 32'd0);
    reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    step();
    xfer(1'b0, 2'd2, 1'b0, 32'h8, 32'd0);
`ifdef DMEM_CLEAR_EN
    chk("reset_store_dropped", last_rdata, 32'h00000000);
`else
    chk("reset_store_dropped", last_rdata, 32'h00000055);
`endif

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      reset        = ($urandom_range(0, 299) == 0);
      req_valid    = ($urandom_range(0, 9) < 7);
      req_we       = $urandom_range(0, 1) == 1;
      req_size     = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      req_unsigned = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) != 0) req_addr = 32'($urandom_range(0, 63));
      else if ($urandom_range(0, 1) == 0) req_addr = 32'($urandom_range(64, 200));
      else req_addr = $urandom;
      req_wdata = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
